cpu0_jtag_debug_scan_master: RTL and testbench
==============================================

# cpu0_jtag_debug_scan_master

Host-side scan initiator for the CPU0 JTAG debug module's virtual-JTAG port. It drives the same signal set that the SLD virtual JTAG node presents to the debug module: tck, tdi, ir_in, and the uir/cdr/sdr/udr/rti strobes. It captures tdo and ir_out in return. A command-level handshake lets an on-chip test controller or simulation bench issue complete 38-bit data-register scans without a physical JTAG cable.

## Interface
Parameters:
- SR_WIDTH, 38, data-register scan length in bits (≥2)
- IR_WIDTH, 2, virtual instruction width
- TCK_DIV, 2, clk cycles per tck half-period (≥1)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  scan request
- cmd_ready  out  1  high only in IDLE
- cmd_ir  in  IR_WIDTH  instruction to load during UIR
- cmd_data  in  SR_WIDTH  data shifted out on tdi, LSB first
- rsp_valid  out  1  one-cycle pulse, scan complete
- rsp_data  out  SR_WIDTH  tdo bits captured during SDR, bit 0 = first captured
- rsp_ir_out  out  IR_WIDTH  vji_ir_out sampled during UIR
- busy  out  1  high from accept through the rsp_valid cycle
- vji_tck  out  1  generated tck
- vji_tdi  out  1  serial data to slave
- vji_tdo  in  1  serial data from slave
- vji_ir_in  out  IR_WIDTH  instruction to slave; holds value after scan
- vji_ir_out  in  IR_WIDTH  status from slave
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1  virtual TAP state strobes

## Operation
- FSM states: IDLE → UIR → CDR → SDR → UDR → DONE → IDLE.
- One "tck period" is 2·TCK_DIV clk cycles:
  - tck low for the first TCK_DIV cycles, high for the next TCK_DIV.
  - A tck rising edge occurs when tck goes 0→1.
- IDLE:
  - vji_rti=1, all other strobes 0, tck held 0, cmd_ready=1.
  - On cmd_valid&cmd_ready, latch cmd_ir into vji_ir_in and cmd_data into the tx shift register, then go to UIR.
- UIR: 1 tck period with vji_uir=1. rsp_ir_out samples vji_ir_out on that period's tck rise.
- CDR: 1 tck period with vji_cdr=1.
- SDR: SR_WIDTH tck periods with vji_sdr=1.
  - Period i drives vji_tdi = cmd_data[i]. tdi changes only while tck is low.
  - On each tck rise, vji_tdo shifts into rx[SR_WIDTH-1] and rx shifts right. After SR_WIDTH periods, rx[0] holds the first captured bit.
  - A bit counter runs 0..SR_WIDTH-1. The SDR→UDR exit happens when count=SR_WIDTH-1 at period end.
- UDR: 1 tck period with vji_udr=1, tdi=0.
- DONE: 1 clk cycle with rsp_valid=1 and rsp_data=rx, then IDLE.
- rsp_data and rsp_ir_out hold their values until the next DONE.
- Exactly one strobe among uir/cdr/sdr/udr/rti is high at any time. During DONE, rti=1.
- A cmd_valid that arrives while not in IDLE is not accepted. Requesters must hold cmd_valid until cmd_ready.
- Reset mid-scan aborts the scan immediately: no rsp_valid, and vji_ir_in returns to 0.

## Timing
Reset values:
- tck=0, tdi=0
- vji_ir_in=0
- uir=cdr=sdr=udr=0, rti=1
- cmd_ready=1, busy=0
- rsp_valid=0, rsp_data=0, rsp_ir_out=0

Accept and scan latency:
- The accept edge is the rising edge at which cmd_valid&cmd_ready is sampled high. On the next cycle, state=UIR, tck=0, cmd_ready=0, busy=1.
- The scan occupies (SR_WIDTH+3)·2·TCK_DIV cycles: 164 at defaults. rsp_valid is high on the cycle immediately after.
- At defaults, rsp_valid is high exactly 165 cycles after the accept edge.
- cmd_ready returns to 1 the cycle after rsp_valid, so the minimum issue interval is 166 cycles at defaults.

Edge alignment:
- Strobe transitions and tdi changes occur only on cycles where tck goes 1→0, or at state entry while tck=0. They never coincide with a tck rise.
- tdo and ir_out are sampled on the clk edge that drives tck 0→1.
- TCK_DIV=1 gives tck = clk/2 and must work.

## Test plan
- Loopback with vji_tdo tied to vji_tdi through a slave model that samples on tck rise:
  - cmd_ir=2'b01, cmd_data=38'h25_DEAD_BEEF → rsp_data=38'h25_DEAD_BEEF.
  - rsp_valid lands 165 cycles after accept.
  - vji_ir_in=2'b01 throughout and after the scan.
- Slave model returns a fixed pattern 38'h1A_5A5A_A5A5 LSB-first; vji_ir_out=2'b10 → rsp_data=38'h1A_5A5A_A5A5, rsp_ir_out=2'b10.
- Sequence check:
  - Strobe order is rti, uir(4 cycles), cdr(4), sdr(152), udr(4), rti.
  - Strobes are one-hot on every cycle.
  - Exactly 38 tck rises during sdr.
- Back-to-back commands with cmd_valid held high:
  - The second scan starts 166 cycles after the first accept.
  - cmd_ready is 0 for all cycles in between.
- Assert reset_n=0 mid-SDR (bit 17) for 1 cycle:
  - Outputs take their reset values asynchronously.
  - No rsp_valid appears.
  - A next command completes normally.
- TCK_DIV=1, SR_WIDTH=8, loopback data 8'hC3 → rsp_data=8'hC3, rsp_valid 23 cycles after accept.

Source files
------------

// File: rtl/cpu0_jtag_debug_scan_master.sv
// Host-side scan initiator for the CPU0 debug module's virtual-JTAG port.
// Runs one UIR/CDR/SDR/UDR sequence per accepted command and returns the captured tdo bits.
module cpu0_jtag_debug_scan_master #(
  parameter int SR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [SR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [SR_WIDTH-1:0] rsp_data,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                busy,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_UIR  = 3'd1;
  localparam logic [2:0] S_CDR  = 3'd2;
  localparam logic [2:0] S_SDR  = 3'd3;
  localparam logic [2:0] S_UDR  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam int PH_W  = (2 * TCK_DIV > 1) ? $clog2(2 * TCK_DIV) : 1;
  localparam int CNT_W = (SR_WIDTH > 1) ? $clog2(SR_WIDTH) : 1;

  // Phase counter walks one tck period: low half first, then high half.
  localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(TCK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(TCK_DIV);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * TCK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SR_WIDTH - 1);

  logic [2:0]          state_q, state_d;
  logic [PH_W-1:0]     ph_q, ph_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SR_WIDTH-1:0] tx_q, tx_d;
  logic [SR_WIDTH-1:0] rx_q, rx_d;
  logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
  logic [IR_WIDTH-1:0] ir_cap_q, ir_cap_d;
  logic [SR_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [IR_WIDTH-1:0] rsp_ir_q, rsp_ir_d;

  logic active;
  logic tck_rise;
  logic period_end;

  always_comb begin
    active     = (state_q == S_UIR) || (state_q == S_CDR) ||
                 (state_q == S_SDR) || (state_q == S_UDR);
    tck_rise   = active && (ph_q == PH_RISE);
    period_end = active && (ph_q == PH_LAST);

    state_d    = state_q;
    ph_d       = '0;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    ir_in_d    = ir_in_q;
    ir_cap_d   = ir_cap_q;
    rsp_data_d = rsp_data_q;
    rsp_ir_d   = rsp_ir_q;

    if (active && !period_end) begin
      ph_d = ph_q + PH_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          ir_in_d = cmd_ir;
          tx_d    = cmd_data;
          cnt_d   = '0;
          state_d = S_UIR;
        end
      end
      S_UIR: begin
        if (tck_rise) begin
          ir_cap_d = vji_ir_out;
        end
        if (period_end) begin
          state_d = S_CDR;
        end
      end
      S_CDR: begin
        if (period_end) begin
          state_d = S_SDR;
        end
      end
      S_SDR: begin
        if (tck_rise) begin
          rx_d = {vji_tdo, rx_q[SR_WIDTH-1:1]};
        end
        if (period_end) begin
          tx_d = tx_q >> 1;
          if (cnt_q == CNT_LAST) begin
            state_d = S_UDR;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_UDR: begin
        // Results are published together so they stay stable between completions.
        if (period_end) begin
          rsp_data_d = rx_q;
          rsp_ir_d   = ir_cap_q;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      ph_q       <= '0;
      cnt_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      ir_in_q    <= '0;
      ir_cap_q   <= '0;
      rsp_data_q <= '0;
      rsp_ir_q   <= '0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      ir_in_q    <= ir_in_d;
      ir_cap_q   <= ir_cap_d;
      rsp_data_q <= rsp_data_d;
      rsp_ir_q   <= rsp_ir_d;
    end
  end

  // Outputs decode straight from state so reset forces them without waiting for a clock.
  assign vji_tck    = active && (ph_q >= PH_HALF);
  assign vji_tdi    = (state_q == S_SDR) && tx_q[0];
  assign vji_ir_in  = ir_in_q;
  assign vji_uir    = (state_q == S_UIR);
  assign vji_cdr    = (state_q == S_CDR);
  assign vji_sdr    = (state_q == S_SDR);
  assign vji_udr    = (state_q == S_UDR);
  assign vji_rti    = (state_q == S_IDLE) || (state_q == S_DONE);
  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign rsp_valid  = (state_q == S_DONE);
  assign rsp_data   = rsp_data_q;
  assign rsp_ir_out = rsp_ir_q;

endmodule

// File: tb/tb_cpu0_jtag_debug_scan_master.sv
// Bench for cpu0_jtag_debug_scan_master: vector table on the default build plus
// hand-written back-to-back, mid-scan reset and fast-tck (TCK_DIV=1, 8-bit) sequences.
module tb_cpu0_jtag_debug_scan_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_data;
  logic        rsp_valid;
  logic [37:0] rsp_data;
  logic [1:0]  rsp_ir_out;
  logic        busy;
  logic        vji_tck, vji_tdi, vji_tdo;
  logic [1:0]  vji_ir_in;
  logic [1:0]  vji_ir_out;
  logic        vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

  logic        cmd_valid8;
  logic        cmd_ready8;
  logic [1:0]  cmd_ir8;
  logic [7:0]  cmd_data8;
  logic        rsp_valid8;
  logic [7:0]  rsp_data8;
  logic [1:0]  rsp_ir_out8;
  logic        busy8;
  logic        vji_tck8, vji_tdi8, vji_tdo8;
  logic [1:0]  vji_ir_in8;
  logic [1:0]  vji_ir_out8;
  logic        vji_uir8, vji_cdr8, vji_sdr8, vji_udr8, vji_rti8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu0_jtag_debug_scan_master dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ir_out(rsp_ir_out), .busy(busy),
    .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
    .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
    .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
  );

  cpu0_jtag_debug_scan_master #(.SR_WIDTH(8), .IR_WIDTH(2), .TCK_DIV(1)) dut8 (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid8), .cmd_ready(cmd_ready8), .cmd_ir(cmd_ir8), .cmd_data(cmd_data8),
    .rsp_valid(rsp_valid8), .rsp_data(rsp_data8), .rsp_ir_out(rsp_ir_out8), .busy(busy8),
    .vji_tck(vji_tck8), .vji_tdi(vji_tdi8), .vji_tdo(vji_tdo8),
    .vji_ir_in(vji_ir_in8), .vji_ir_out(vji_ir_out8),
    .vji_uir(vji_uir8), .vji_cdr(vji_cdr8), .vji_sdr(vji_sdr8), .vji_udr(vji_udr8), .vji_rti(vji_rti8)
  );

  // Slave model: either a wire loopback or a fixed pattern stepped on each SDR tck rise.
  bit          patMode = 1'b0;
  logic [37:0] slvPat = '0;
  int          slvIdx = 0;

  always @(posedge vji_tck) begin
    if (vji_cdr) slvIdx = 0;
    else if (vji_sdr && slvIdx < 37) slvIdx = slvIdx + 1;
  end

  assign vji_tdo     = patMode ? slvPat[slvIdx[5:0]] : vji_tdi;
  assign vji_tdo8    = vji_tdi8;
  assign vji_ir_out8 = 2'b00;

  // Strobe monitor on the default instance, sampled on the falling clk edge.
  bit         monOn = 1'b0;
  logic [1:0] monIr = '0;
  int uirCnt, cdrCnt, sdrCnt, udrCnt, sdrRises, ohErr, orderErr, irErr, lastCode;
  logic prevTck;

  task automatic clearMonitor();
    uirCnt = 0; cdrCnt = 0; sdrCnt = 0; udrCnt = 0; sdrRises = 0;
    ohErr = 0; orderErr = 0; irErr = 0; lastCode = 0; prevTck = 1'b0;
  endtask

  always @(negedge clk) begin
    if (monOn) begin
      int code;
      code = vji_uir ? 1 : vji_cdr ? 2 : vji_sdr ? 3 : vji_udr ? 4 : 0;
      if ($countones({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}) != 1) ohErr++;
      if (code != lastCode && code != lastCode + 1 && !(lastCode == 4 && code == 0)) orderErr++;
      lastCode = code;
      if (vji_uir) uirCnt++;
      if (vji_cdr) cdrCnt++;
      if (vji_sdr) sdrCnt++;
      if (vji_udr) udrCnt++;
      if (vji_sdr && vji_tck && !prevTck) sdrRises++;
      if (busy && vji_ir_in !== monIr) irErr++;
      prevTck = vji_tck;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("idleBeforeCmd", 64'(cmd_ready), 64'd1);
  endtask

  // Issues one command on the default instance; lat = clk edges from accept to rsp_valid.
  task automatic applyStimulus(input logic [1:0] ir, input logic [37:0] data, output int lat);
    waitIdle();
    @(negedge clk);
    clearMonitor();
    monIr = ir;
    monOn = 1'b1;
    cmd_ir = ir;
    cmd_data = data;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checkOutput("acceptReadyLow", 64'(cmd_ready), 64'd0);
    checkOutput("acceptBusy", 64'(busy), 64'd1);
    checkOutput("acceptUir", 64'(vji_uir), 64'd1);
    checkOutput("acceptTckLow", 64'(vji_tck), 64'd0);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 1000) begin
      @(posedge clk); #1;
      lat++;
    end
    monOn = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  ir;
    logic [37:0] data;
    bit          patMode;
    logic [37:0] pat;
    logic [1:0]  irOut;
    logic [37:0] expData;
    logic [1:0]  expIr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat;
    vecs[0] = '{2'b01, 38'h25_DEAD_BEEF, 1'b0, 38'h0,           2'b00, 38'h25_DEAD_BEEF, 2'b00};
    vecs[1] = '{2'b11, 38'h3F_0000_1234, 1'b1, 38'h1A_5A5A_A5A5, 2'b10, 38'h1A_5A5A_A5A5, 2'b10};
    vecs[2] = '{2'b10, 38'h00_0000_0001, 1'b0, 38'h0,           2'b01, 38'h00_0000_0001, 2'b01};
    vecs[3] = '{2'b11, 38'h3F_FFFF_FFFF, 1'b0, 38'h0,           2'b11, 38'h3F_FFFF_FFFF, 2'b11};
    vecs[4] = '{2'b00, 38'h15_5555_5555, 1'b1, 38'h20_0000_0000, 2'b01, 38'h20_0000_0000, 2'b01};

    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_ir = '0; cmd_data = '0;
    cmd_valid8 = 1'b0; cmd_ir8 = '0; cmd_data8 = '0;
    vji_ir_out = '0;
    clearMonitor();
    #1;
    checkOutput("rstTck", 64'(vji_tck), 64'd0);
    checkOutput("rstTdi", 64'(vji_tdi), 64'd0);
    checkOutput("rstIrIn", 64'(vji_ir_in), 64'd0);
    checkOutput("rstStrobes", 64'({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'b00001);
    checkOutput("rstReadyBusy", 64'({cmd_ready, busy}), 64'b10);
    checkOutput("rstRsp", 64'({rsp_valid, rsp_data, rsp_ir_out}), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      patMode = vecs[i].patMode;
      slvPat = vecs[i].pat;
      vji_ir_out = vecs[i].irOut;
      applyStimulus(vecs[i].ir, vecs[i].data, lat);
      // rsp_valid is visible in the 165th cycle after accept, i.e. after 164 more edges.
      checkOutput($sformatf("v%0d.latency", i), 64'(lat), 64'd164);
      checkOutput($sformatf("v%0d.rspData", i), 64'(rsp_data), 64'(vecs[i].expData));
      checkOutput($sformatf("v%0d.rspIrOut", i), 64'(rsp_ir_out), 64'(vecs[i].expIr));
      checkOutput($sformatf("v%0d.irIn", i), 64'(vji_ir_in), 64'(vecs[i].ir));
      checkOutput($sformatf("v%0d.doneRti", i), 64'(vji_rti), 64'd1);
      checkOutput($sformatf("v%0d.uirCycles", i), 64'(uirCnt), 64'd4);
      checkOutput($sformatf("v%0d.cdrCycles", i), 64'(cdrCnt), 64'd4);
      checkOutput($sformatf("v%0d.sdrCycles", i), 64'(sdrCnt), 64'd152);
      checkOutput($sformatf("v%0d.udrCycles", i), 64'(udrCnt), 64'd4);
      checkOutput($sformatf("v%0d.sdrTckRises", i), 64'(sdrRises), 64'd38);
      checkOutput($sformatf("v%0d.oneHotErrs", i), 64'(ohErr), 64'd0);
      checkOutput($sformatf("v%0d.orderErrs", i), 64'(orderErr), 64'd0);
      checkOutput($sformatf("v%0d.irInErrs", i), 64'(irErr), 64'd0);
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d.readyAfter", i), 64'({cmd_ready, busy, rsp_valid}), 64'b100);
      checkOutput($sformatf("v%0d.rspHeld", i), 64'(rsp_data), 64'(vecs[i].expData));
      checkOutput($sformatf("v%0d.irInHeld", i), 64'(vji_ir_in), 64'(vecs[i].ir));
    end

    // Back-to-back: cmd_valid held high; the second command must wait for IDLE.
    begin
      int n, firstRsp, readyEdge, secondAccept, earlyReady;
      patMode = 1'b0;
      waitIdle();
      @(negedge clk);
      cmd_ir = 2'b01; cmd_data = 38'h15_5555_AAAA; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_ir = 2'b10; cmd_data = 38'h0A_AAAA_5555;
      n = 0; firstRsp = -1; readyEdge = -1; secondAccept = -1; earlyReady = 0;
      while (secondAccept < 0 && n < 400) begin
        @(posedge clk); #1;
        n++;
        if (rsp_valid && firstRsp < 0) begin
          firstRsp = n;
          checkOutput("b2b.firstData", 64'(rsp_data), 64'h15_5555_AAAA);
        end
        if (cmd_ready) begin
          if (n <= 164) earlyReady++;
          if (readyEdge < 0) readyEdge = n;
        end else if (readyEdge >= 0) begin
          secondAccept = n;
        end
      end
      cmd_valid = 1'b0;
      checkOutput("b2b.firstRspEdge", 64'(firstRsp), 64'd164);
      checkOutput("b2b.readyEdge", 64'(readyEdge), 64'd165);
      checkOutput("b2b.secondAccept", 64'(secondAccept), 64'd166);
      checkOutput("b2b.readyLowBetween", 64'(earlyReady), 64'd0);
      checkOutput("b2b.secondIrIn", 64'(vji_ir_in), 64'b10);
      n = 0;
      while (rsp_valid !== 1'b1 && n < 1000) begin
        @(posedge clk); #1;
        n++;
      end
      checkOutput("b2b.secondLatency", 64'(n), 64'd164);
      checkOutput("b2b.secondData", 64'(rsp_data), 64'h0A_AAAA_5555);
    end

    // Reset pulse in the middle of SDR bit 17, then a clean scan.
    begin
      int n, sawRsp;
      patMode = 1'b0;
      waitIdle();
      @(negedge clk);
      cmd_ir = 2'b11; cmd_data = 38'h2A_1234_5678; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (78) @(posedge clk);
      #1;
      checkOutput("rstMid.inSdr", 64'(vji_sdr), 64'd1);
      reset_n = 1'b0;
      #1;
      checkOutput("rstMid.strobes", 64'({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'b00001);
      checkOutput("rstMid.tckTdi", 64'({vji_tck, vji_tdi}), 64'd0);
      checkOutput("rstMid.irIn", 64'(vji_ir_in), 64'd0);
      checkOutput("rstMid.readyBusy", 64'({cmd_ready, busy}), 64'b10);
      checkOutput("rstMid.rsp", 64'({rsp_valid, rsp_data, rsp_ir_out}), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      sawRsp = 0;
      for (n = 0; n < 200; n++) begin
        @(posedge clk); #1;
        if (rsp_valid) sawRsp++;
      end
      checkOutput("rstMid.noRsp", 64'(sawRsp), 64'd0);
      vji_ir_out = 2'b10;
      applyStimulus(2'b01, 38'h25_DEAD_BEEF, n);
      checkOutput("rstMid.nextLatency", 64'(n), 64'd164);
      checkOutput("rstMid.nextData", 64'(rsp_data), 64'h25_DEAD_BEEF);
      checkOutput("rstMid.nextIrOut", 64'(rsp_ir_out), 64'b10);
    end

    // Fast tck build: TCK_DIV=1, 8-bit register, loopback.
    begin
      int n;
      @(negedge clk);
      checkOutput("fast.idleReady", 64'(cmd_ready8), 64'd1);
      cmd_ir8 = 2'b01; cmd_data8 = 8'hC3; cmd_valid8 = 1'b1;
      @(posedge clk); #1;
      cmd_valid8 = 1'b0;
      checkOutput("fast.acceptBusy", 64'(busy8), 64'd1);
      n = 0;
      while (rsp_valid8 !== 1'b1 && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      checkOutput("fast.latency", 64'(n), 64'd22);
      checkOutput("fast.rspData", 64'(rsp_data8), 64'hC3);
      checkOutput("fast.irIn", 64'(vji_ir_in8), 64'b01);
      checkOutput("fast.rspIrOut", 64'(rsp_ir_out8), 64'b00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
